// File: rtl/wide_placer_pkg.sv
// Shared types and defaults for the wide constant placer.
// Mode/state enumerators carry prefixes so WALK can exist in both enums.
package wide_placer_pkg;

    typedef enum logic [1:0] {
        MODE_CLEAR    = 2'd0,
        MODE_PLACE_HI = 2'd1,
        MODE_PLACE_LO = 2'd2,
        MODE_WALK     = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } state_e;

    localparam logic [63:0] DEFAULT_PATTERN = 64'hffff0000ffff0000;

endpackage

// File: rtl/wide_placer_shift.sv
// Combinational anchor/shift/truncate of the constant pattern into a WIDTH-bit word.
// Arithmetic is carried at WIDTH+PAT_W bits so no pattern bit is lost before the final slice.
module wide_placer_shift
    import wide_placer_pkg::*;
#(
    parameter int               WIDTH   = 1050,
    parameter int               PAT_W   = 64,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN[PAT_W-1:0],
    parameter int               OFS_W   = $clog2(WIDTH)
) (
    input  logic             place_hi,
    input  logic [OFS_W:0]   ofs,
    output logic [WIDTH-1:0] data,
    output logic             err,
    output logic             big
);

    localparam int             EXT_W = WIDTH + PAT_W;
    localparam logic [OFS_W:0] LIM_W = (OFS_W+1)'(WIDTH);
    localparam logic [OFS_W:0] LIM_T = (OFS_W+1)'(WIDTH - PAT_W);

    logic [EXT_W-1:0] lo_ext;
    logic [EXT_W-1:0] hi_ext;
    logic             unused_bits;

    assign lo_ext = {{WIDTH{1'b0}}, PATTERN} << ofs;
    assign hi_ext = {PATTERN, {WIDTH{1'b0}}} >> ofs;

    // Bits shifted past either end of the output window are discarded here.
    assign unused_bits = ^{lo_ext[EXT_W-1:WIDTH], hi_ext[PAT_W-1:0]};

    assign big = (ofs >= LIM_W);
    assign err = big || (ofs > LIM_T);

    always_comb begin
        data = '0;
        if (!big) begin
            data = place_hi ? hi_ext[EXT_W-1:PAT_W] : lo_ext[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/wide_const_placer.sv
// Places a fixed constant into a wide registered word: clear, anchor hi/lo, or walk upward.
// Optional out_par port (XOR of out_data) is enabled by defining WIDE_PLACER_PARITY_EN.
//
// state   | meaning
// ST_IDLE | ready for a request; CLEAR/PLACE_* complete in one beat here
// ST_WALK | emitting walk beats at the accumulated offset; requests ignored
module wide_const_placer
    import wide_placer_pkg::*;
#(
    parameter int               WIDTH   = 1050,
    parameter int               PAT_W   = 64,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN[PAT_W-1:0],
    parameter int               STEP    = 64,
    parameter int               OFS_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic [OFS_W-1:0] req_ofs,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             done,
    output logic             err_ofs
`ifdef WIDE_PLACER_PARITY_EN
    ,
    output logic             out_par
`endif
);

    state_e           state, state_nxt;
    mode_e            mode;
    logic [OFS_W:0]   acc, acc_nxt;
    logic [OFS_W:0]   ofs_sel;
    logic [OFS_W+1:0] ofs_adv;
    logic             walk_last;
    logic             place_hi;
    logic [WIDTH-1:0] shift_data;
    logic             shift_err;
    logic             shift_big;
    logic [WIDTH-1:0] data_nxt;
    logic             valid_nxt, done_nxt, err_nxt;

    assign mode      = mode_e'(req_mode);
    assign req_ready = (state == ST_IDLE);
    assign ofs_sel   = (state == ST_WALK) ? acc : {1'b0, req_ofs};
    assign place_hi  = (state == ST_IDLE) && (mode == MODE_PLACE_HI);

    // One extra bit so the look-ahead never wraps, even from the largest request offset.
    assign ofs_adv   = {1'b0, ofs_sel} + (OFS_W+2)'(STEP);
    assign walk_last = (ofs_adv >= (OFS_W+2)'(WIDTH));

    wide_placer_shift #(
        .WIDTH   (WIDTH),
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .OFS_W   (OFS_W)
    ) u_shift (
        .place_hi (place_hi),
        .ofs      (ofs_sel),
        .data     (shift_data),
        .err      (shift_err),
        .big      (shift_big)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        data_nxt  = out_data;
        valid_nxt = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    valid_nxt = 1'b1;
                    case (mode)
                        MODE_PLACE_HI, MODE_PLACE_LO: begin
                            data_nxt = shift_data;
                            done_nxt = 1'b1;
                            err_nxt  = shift_err;
                        end
                        MODE_WALK: begin
                            data_nxt = shift_data;
                            if (walk_last) begin
                                done_nxt = 1'b1;
                                err_nxt  = shift_err;
                            end else begin
                                state_nxt = ST_WALK;
                                acc_nxt   = ofs_adv[OFS_W:0];
                            end
                        end
                        default: begin
                            data_nxt = '0;
                            done_nxt = 1'b1;
                            err_nxt  = shift_big;
                        end
                    endcase
                end
            end
            ST_WALK: begin
                valid_nxt = 1'b1;
                data_nxt  = shift_data;
                if (walk_last) begin
                    done_nxt  = 1'b1;
                    err_nxt   = shift_err;
                    state_nxt = ST_IDLE;
                end else begin
                    acc_nxt = ofs_adv[OFS_W:0];
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err_ofs   <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            done      <= done_nxt;
            err_ofs   <= err_nxt;
        end
    end

`ifdef WIDE_PLACER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par <= 1'b0;
        end else if (valid_nxt) begin
            out_par <= ^data_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_wide_const_placer.sv
// Directed bench for wide_const_placer at default parameters (WIDTH=1050, STEP=64).
module tb_wide_const_placer;
    import wide_placer_pkg::*;

    localparam int          W   = 1050;
    localparam int          OW  = 11;
    localparam logic [63:0] PAT = 64'hffff0000ffff0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  pad_lo = '1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_mode = 2'd0;
    logic [OW-1:0] req_ofs = '0;
    logic [W-1:0]  out_data;
    logic [W-1:0]  pad_hi = '1;
    logic          out_valid, done, err_ofs;
`ifdef WIDE_PLACER_PARITY_EN
    logic          out_par;
`endif

    int n_chk = 0;
    int n_bad = 0;
    logic [63:0] pat_v;
    logic [W-1:0] exp_v;

    wide_const_placer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_ofs   (req_ofs),
        .out_data  (out_data),
        .out_valid (out_valid),
        .done      (done),
        .err_ofs   (err_ofs)
`ifdef WIDE_PLACER_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        for (int w = 0; w < 17; w++) begin
            chk($sformatf("%s[w%0d]", tag, w), 64'(got >> (64*w)), 64'(exp >> (64*w)));
        end
    endtask

    function automatic logic [W-1:0] model_lo(input int ofs, input logic [63:0] p);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < 64; j++)
            if (ofs + j < W) r[ofs+j] = p[j];
        return r;
    endfunction

    function automatic logic [W-1:0] model_hi(input int ofs, input logic [63:0] p);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < 64; j++)
            if (W - 64 - ofs + j >= 0) r[W-64-ofs+j] = p[j];
        return r;
    endfunction

    // Drive one request at posedge+1; return sampled at the following posedge+1.
    task automatic send(input logic [1:0] mode, input int ofs);
        req_valid = 1'b1;
        req_mode  = mode;
        req_ofs   = OW'(ofs);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic single(input string tag, input logic [1:0] mode, input int ofs,
                          input logic [W-1:0] exp, input logic exp_err);
        send(mode, ofs);
        chk_wide({tag, "_data"}, out_data, exp);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_err"}, 64'(err_ofs), 64'(exp_err));
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        pat_v = PAT;
        #2;
        chk_wide("rst_data", out_data, '0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_ofs), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        exp_v = {986'd0, 64'hffff0000ffff0000};
        single("lo0", 2'd2, 0, exp_v, 1'b0);
        @(posedge clk); #1;
        chk("lo0_done_pulse", 64'(done), 64'd0);
        chk("lo0_valid_pulse", 64'(out_valid), 64'd0);

        exp_v = {64'hffff0000ffff0000, 986'd0};
        single("hi0", 2'd1, 0, exp_v, 1'b0);
        single("clr", 2'd0, 5, '0, 1'b0);

        exp_v = '0;
        exp_v[1049:1000] = pat_v[49:0];
        single("lo1000", 2'd2, 1000, exp_v, 1'b1);
        single("lo986", 2'd2, 986, model_lo(986, pat_v), 1'b0);
        single("lo1049", 2'd2, 1049, '0, 1'b1);
        single("lo1050", 2'd2, 1050, '0, 1'b1);
        single("hi986", 2'd1, 986, {986'd0, 64'hffff0000ffff0000}, 1'b0);
        exp_v = '0;
        exp_v[62:0] = pat_v[63:1];
        single("hi987", 2'd1, 987, exp_v, 1'b1);
        single("hi300", 2'd1, 300, model_hi(300, pat_v), 1'b0);
        single("clr_big", 2'd0, 2000, '0, 1'b1);

        // Walk from 0; a held CLEAR request during the walk must be ignored.
        send(2'd3, 0);
        req_valid = 1'b1;
        req_mode  = 2'd0;
        for (int k = 0; k < 17; k++) begin
            if (k == 14) req_valid = 1'b0;
            chk_wide($sformatf("walk%0d", k), out_data, model_lo(64*k, pat_v));
            chk($sformatf("walk%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("walk%0d_done", k), 64'(done), 64'(k == 16));
            chk($sformatf("walk%0d_err", k), 64'(err_ofs), 64'(k == 16));
            if (k < 16) chk($sformatf("walk%0d_ready", k), 64'(req_ready), 64'd0);
            if (k < 16) begin @(posedge clk); #1; end
        end
        exp_v = '0;
        exp_v[1049:1024] = pat_v[25:0];
        chk_wide("walk_last", out_data, exp_v);
        @(posedge clk); #1;
        chk("walk_after_ready", 64'(req_ready), 64'd1);
        chk("walk_after_valid", 64'(out_valid), 64'd0);

        // Walk interrupted by reset after beat 5.
        send(2'd3, 0);
        for (int k = 0; k < 6; k++) begin
            chk_wide($sformatf("wr%0d", k), out_data, model_lo(64*k, pat_v));
            if (k < 5) begin @(posedge clk); #1; end
        end
        #1 rst_n = 1'b0;
        #1;
        chk_wide("wr_rst_data", out_data, '0);
        chk("wr_rst_valid", 64'(out_valid), 64'd0);
        chk("wr_rst_done", 64'(done), 64'd0);
        chk("wr_rst_err", 64'(err_ofs), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("wr_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        chk("wr_idle_valid", 64'(out_valid), 64'd0);
        single("wr_lo64", 2'd2, 64, model_lo(64, pat_v), 1'b0);

        chk_wide("pad_lo", pad_lo, '1);
        chk_wide("pad_hi", pad_hi, '1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
